// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
//   Walks a 3x3 window across an IMG_W x IMG_H image stored one 32-bit word
//   per pixel. For every window position it fetches the nine pixels and
//   presents them to an external dot-product unit. It then waits for that
//   unit's result and writes the result to a (IMG_W-2) x (IMG_H-2) result
//   memory in row-major order.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   start                : begin one full-image pass (sampled in IDLE only)
//   busy, done           : pass in progress / one-cycle end-of-pass pulse
//   img_rd_en/addr/data  : image memory read port (data valid 1 cycle later)
//   win_flat             : nine window words, word k at bits [32k+31:32k]
//   dot_initate          : one-cycle start pulse to the dot-product unit
//   dot_ready/dot_result : completion flag and result from the dot-product unit
//   res_wr_en/addr/data  : result memory write port
//
// Build option
//   SCHED_RELU_EN : when defined, negative results (bit 31 set) are written as 0.
module conv_window_scheduler #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          img_rd_en,
    output logic [AW-1:0] img_rd_addr,
    input  logic [31:0]   img_rd_data,
    output logic [287:0]  win_flat,
    output logic          dot_initate,
    input  logic          dot_ready,
    input  logic [31:0]   dot_result,
    output logic          res_wr_en,
    output logic [AW-1:0] res_wr_addr,
    output logic [31:0]   res_wr_data
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LAST, FIRE, WAIT_DOT, WRITE, ADV, FIN
    } state_t;

    localparam logic [AW-1:0] IMG_W_A  = AW'(IMG_W);
    localparam logic [AW-1:0] RES_W_A  = AW'(IMG_W - 2);
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 3);
    localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 3);

    state_t        state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] col_q, col_d;
    logic [31:0]   win_q [0:8];
    logic [31:0]   win_d [0:8];

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          dot_init_q, dot_init_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;

    // Row / column offset of window element k inside the 3x3 window.
    function automatic logic [AW-1:0] k_row(input logic [3:0] k);
        case (k)
            4'd3, 4'd4, 4'd5: return AW'(1);
            4'd6, 4'd7, 4'd8: return AW'(2);
            default:          return '0;
        endcase
    endfunction

    function automatic logic [AW-1:0] k_col(input logic [3:0] k);
        case (k)
            4'd1, 4'd4, 4'd7: return AW'(1);
            4'd2, 4'd5, 4'd8: return AW'(2);
            default:          return '0;
        endcase
    endfunction

    function automatic logic [31:0] post_proc(input logic [31:0] v);
`ifdef SCHED_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        win_d     = win_q;
        wr_data_d = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Data of read k-1 arrives while read k is being issued.
                if (k_q != 4'd0) begin
                    win_d[k_q - 4'd1] = img_rd_data;
                end
                if (k_q == 4'd8) begin
                    k_d     = '0;
                    state_d = LAST;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            LAST: begin
                win_d[8] = img_rd_data;
                state_d  = FIRE;
            end
            FIRE: state_d = WAIT_DOT;
            WAIT_DOT: begin
                if (dot_ready) begin
                    wr_data_d = post_proc(dot_result);
                    state_d   = WRITE;
                end
            end
            WRITE: state_d = ADV;
            ADV: begin
                if (col_q == COL_LAST) begin
                    if (row_q == ROW_LAST) begin
                        state_d = FIN;
                    end else begin
                        col_d   = '0;
                        row_d   = row_q + AW'(1);
                        state_d = FETCH;
                    end
                end else begin
                    col_d   = col_q + AW'(1);
                    state_d = FETCH;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the next state so they register cleanly.
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        rd_en_d    = (state_d == FETCH);
        rd_addr_d  = rd_en_d ? ((row_d + k_row(k_d)) * IMG_W_A + col_d + k_col(k_d)) : '0;
        dot_init_d = (state_d == FIRE);
        wr_en_d    = (state_d == WRITE);
        wr_addr_d  = wr_en_d ? (row_d * RES_W_A + col_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            win_q      <= '{default: '0};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            dot_init_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            row_q      <= row_d;
            col_q      <= col_d;
            win_q      <= win_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            dot_init_q <= dot_init_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_win
            assign win_flat[32*gi +: 32] = win_q[gi];
        end
    endgenerate

    assign busy        = busy_q;
    assign done        = done_q;
    assign img_rd_en   = rd_en_q;
    assign img_rd_addr = rd_addr_q;
    assign dot_initate = dot_init_q;
    assign res_wr_en   = wr_en_q;
    assign res_wr_addr = wr_addr_q;
    assign res_wr_data = wr_data_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler on a 4x4 image holding words 0..15,
// with a behavioural image memory and dot-product unit model.
module tb_conv_window_scheduler;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          img_rd_en;
    logic [AW-1:0] img_rd_addr;
    logic [31:0]   img_rd_data;
    logic [287:0]  win_flat;
    logic          dot_initate;
    logic          dot_ready;
    logic [31:0]   dot_result;
    logic          res_wr_en;
    logic [AW-1:0] res_wr_addr;
    logic [31:0]   res_wr_data;

    conv_window_scheduler #(.IMG_W(4), .IMG_H(4), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
        .win_flat(win_flat), .dot_initate(dot_initate), .dot_ready(dot_ready),
        .dot_result(dot_result), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
        .res_wr_data(res_wr_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Image memory: word i holds i, data valid one cycle after the strobe.
    always @(posedge clk) begin
        if (img_rd_en) img_rd_data <= 32'(img_rd_addr[3:0]);
    end

    // Dot-product model: result is the sum of the nine window words, ready
    // dot_delay cycles after the start pulse.
    int          dot_delay;
    bit          force_neg;
    int          dot_cnt;
    logic [31:0] dot_sum;

    function automatic logic [31:0] win_sum(input logic [287:0] w);
        logic [31:0] s = '0;
        for (int i = 0; i < 9; i++) s += w[32*i +: 32];
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dot_cnt <= 0;
            dot_sum <= '0;
        end else if (dot_initate) begin
            dot_cnt <= dot_delay;
            dot_sum <= win_sum(win_flat);
        end else if (dot_cnt != 0) begin
            dot_cnt <= dot_cnt - 1;
        end
    end
    assign dot_ready  = (dot_cnt == 1);
    assign dot_result = force_neg ? 32'hFFFF_FFF6 : dot_sum;

    // Monitor: one line per result write, history kept in queues.
    int          cyc = 0;
    int          rd_start = 0;
    logic        prev_rd = 1'b0;
    int          done_cnt = 0;
    int          init_cnt = 0;
    logic [287:0] win_snap = '0;
    int          rd_q[$];
    int          rd_cyc_q[$];
    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          lat_q[$];
    int          wok_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (img_rd_en && !prev_rd) rd_start = cyc;
            if (img_rd_en) begin
                rd_q.push_back(int'(img_rd_addr));
                rd_cyc_q.push_back(cyc);
            end
            if (dot_initate) begin
                init_cnt++;
                win_snap = win_flat;
            end
            if (res_wr_en) begin
                wa_q.push_back(int'(res_wr_addr));
                wd_q.push_back(res_wr_data);
                lat_q.push_back(cyc - rd_start);
                wok_q.push_back((win_flat == win_snap) ? 1 : 0);
                $display("write addr=%0d data=%0h latency=%0d", res_wr_addr, res_wr_data, cyc - rd_start);
            end
            if (done) done_cnt++;
        end
        prev_rd = img_rd_en;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int b = done_cnt;
        logic to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != b) begin
                to = 1'b0;
                break;
            end
        end
        check("done_timeout", {63'b0, to}, 64'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  {63'b0, busy}, 0);
        check({tag, "_done"},  {63'b0, done}, 0);
        check({tag, "_rden"},  {63'b0, img_rd_en}, 0);
        check({tag, "_rdadr"}, 64'(img_rd_addr), 0);
        check({tag, "_init"},  {63'b0, dot_initate}, 0);
        check({tag, "_wren"},  {63'b0, res_wr_en}, 0);
        check({tag, "_wradr"}, 64'(res_wr_addr), 0);
        check({tag, "_wrdat"}, 64'(res_wr_data), 0);
        check({tag, "_win"},   {63'b0, |win_flat}, 0);
    endtask

    initial begin
        int exp_d[4] = '{45, 54, 81, 90};
        int trace[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int bw, br, bd, bi, i;
        logic [31:0] relu_exp;

        rst = 1'b1; start = 1'b0; dot_delay = 3; force_neg = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Basic pass: results, read trace, latency, done pulse.
        bw = wa_q.size(); br = rd_q.size(); bd = done_cnt;
        pulse_start();
        wait_done(300);
        repeat (5) @(negedge clk);
        check("p1_nwr", 64'(wa_q.size() - bw), 4);
        for (i = 0; i < 4; i++) begin
            check($sformatf("p1_addr%0d", i), 64'(wa_q[bw+i]), 64'(i));
            check($sformatf("p1_data%0d", i), 64'(wd_q[bw+i]), 64'(exp_d[i]));
        end
        for (i = 0; i < 9; i++) check($sformatf("p1_rd%0d", i), 64'(rd_q[br+i]), 64'(trace[i]));
        check("p1_rd_span", 64'(rd_cyc_q[br+8] - rd_cyc_q[br]), 8);
        check("p1_nrd", 64'(rd_q.size() - br), 36);
        check("p1_lat", 64'(lat_q[bw]), 14);
        check("p1_done", 64'(done_cnt - bd), 1);
        check("p1_busy", {63'b0, busy}, 0);

        // start held high for the whole pass.
        bw = wa_q.size(); bd = done_cnt;
        @(negedge clk) start = 1'b1;
        wait_done(300);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_nwr", 64'(wa_q.size() - bw), 4);
        check("hold_done", 64'(done_cnt - bd), 1);
        check("hold_busy", {63'b0, busy}, 0);

        // Extra start pulse while busy is ignored.
        bw = wa_q.size(); bd = done_cnt;
        pulse_start();
        for (i = 0; i < 200 && (wa_q.size() - bw) < 2; i++) @(posedge clk);
        pulse_start();
        wait_done(300);
        repeat (10) @(negedge clk);
        check("restart_nwr", 64'(wa_q.size() - bw), 4);
        check("restart_done", 64'(done_cnt - bd), 1);
        check("restart_last", 64'(wa_q[wa_q.size()-1]), 3);

        // Slow dot unit: single initiate per window, window stable to WRITE.
        dot_delay = 20;
        bw = wa_q.size(); bi = init_cnt;
        pulse_start();
        wait_done(500);
        check("slow_init", 64'(init_cnt - bi), 4);
        check("slow_lat", 64'(lat_q[bw]), 31);
        check("slow_data0", 64'(wd_q[bw]), 45);
        check("slow_data3", 64'(wd_q[bw+3]), 90);
        for (i = 0; i < 4; i++) check($sformatf("slow_win%0d", i), 64'(wok_q[bw+i]), 1);

        // Reset while waiting on the dot unit for the third window.
        bw = wa_q.size(); bi = init_cnt;
        pulse_start();
        for (i = 0; i < 300 && (init_cnt - bi) < 3; i++) @(posedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1 check_idle_zero("midrst");
        @(negedge clk) rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_nwr", 64'(wa_q.size() - bw), 2);
        dot_delay = 3;
        bw = wa_q.size();
        pulse_start();
        wait_done(300);
        check("after_rst_addr0", 64'(wa_q[bw]), 0);
        check("after_rst_data0", 64'(wd_q[bw]), 45);
        check("after_rst_nwr", 64'(wa_q.size() - bw), 4);

        // Negative dot result.
`ifdef SCHED_RELU_EN
        relu_exp = 32'd0;
`else
        relu_exp = 32'hFFFF_FFF6;
`endif
        force_neg = 1'b1;
        bw = wa_q.size();
        pulse_start();
        wait_done(300);
        force_neg = 1'b0;
        check("neg_data", 64'(wd_q[bw]), 64'(relu_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
